// File: rtl/fetch_stage_ctrl.sv
// Fetch stage controller: owns the PC, the imem request handshake and the IF/ID register.
// Parks a returned word while IF/ID is stalled and drains an in-flight request after a flush.
module fetch_stage_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        flush,
  input  logic        PCSrc,
  input  logic [1:0]  jump,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic        fetch_stall
);

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] redirect_pc, redirect_next;
  logic [31:0] hold_instr, hold_instr_next;
  logic [31:0] hold_pc4, hold_pc4_next;
  logic [31:0] ifid_instr_next, ifid_pc4_next;
  logic        ifid_valid_next;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        advance;

  assign pc_plus4 = pc + 32'd4;
  assign advance  = IF_ID_write & PC_write;

  // The branch is the older instruction, so it wins over any jump in the same cycle.
  always_comb begin
    if (PCSrc)
      target = {branch_target[31:2], 2'b00};
    else if (jump == 2'b10)
      target = {jr_target[31:2], 2'b00};
    else
      target = {jump_target[31:2], 2'b00};
  end

  assign imem_req    = (state != HOLD);
  assign imem_addr   = pc;
  assign fetch_stall = (state == DROP) | ((state == FETCH) & ~imem_ready);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    redirect_next   = redirect_pc;
    hold_instr_next = hold_instr;
    hold_pc4_next   = hold_pc4;
    ifid_instr_next = IF_ID_instr;
    ifid_pc4_next   = IF_ID_pc4;
    ifid_valid_next = IF_ID_valid;
    case (state)
      FETCH: begin
        if (flush) begin
          ifid_instr_next = NOP_INSTR;
          ifid_pc4_next   = 32'd0;
          ifid_valid_next = 1'b0;
          hold_instr_next = 32'd0;
          hold_pc4_next   = 32'd0;
          // A request already in flight must finish at its old address before redirecting.
          if (imem_ready) begin
            pc_next = target;
          end else begin
            redirect_next = target;
            state_next    = DROP;
          end
        end else if (imem_ready) begin
          if (advance) begin
            ifid_instr_next = imem_rdata;
            ifid_pc4_next   = pc_plus4;
            ifid_valid_next = 1'b1;
            pc_next         = pc_plus4;
          end else begin
            hold_instr_next = imem_rdata;
            hold_pc4_next   = pc_plus4;
            state_next      = HOLD;
          end
        end else if (IF_ID_write) begin
          ifid_instr_next = NOP_INSTR;
          ifid_pc4_next   = 32'd0;
          ifid_valid_next = 1'b0;
        end
      end
      HOLD: begin
        if (flush) begin
          ifid_instr_next = NOP_INSTR;
          ifid_pc4_next   = 32'd0;
          ifid_valid_next = 1'b0;
          hold_instr_next = 32'd0;
          hold_pc4_next   = 32'd0;
          pc_next         = target;
          state_next      = FETCH;
        end else if (advance) begin
          ifid_instr_next = hold_instr;
          ifid_pc4_next   = hold_pc4;
          ifid_valid_next = 1'b1;
          hold_instr_next = 32'd0;
          hold_pc4_next   = 32'd0;
          pc_next         = pc_plus4;
          state_next      = FETCH;
        end
      end
      DROP: begin
        ifid_instr_next = NOP_INSTR;
        ifid_pc4_next   = 32'd0;
        ifid_valid_next = 1'b0;
        if (flush)
          redirect_next = target;
        if (imem_ready) begin
          pc_next    = flush ? target : redirect_pc;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      redirect_pc <= 32'd0;
      hold_instr  <= 32'd0;
      hold_pc4    <= 32'd0;
      IF_ID_instr <= NOP_INSTR;
      IF_ID_pc4   <= 32'd0;
      IF_ID_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      redirect_pc <= redirect_next;
      hold_instr  <= hold_instr_next;
      hold_pc4    <= hold_pc4_next;
      IF_ID_instr <= ifid_instr_next;
      IF_ID_pc4   <= ifid_pc4_next;
      IF_ID_valid <= ifid_valid_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Randomized bench for fetch_stage_ctrl against a queue-based model of the instruction stream.
module tb_fetch_stage_ctrl;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, PC_write, IF_ID_write, flush, PCSrc;
  logic [1:0]  jump;
  logic [31:0] branch_target, jump_target, jr_target;
  logic        imem_req, imem_ready, IF_ID_valid, fetch_stall;
  logic [31:0] imem_addr, imem_rdata, IF_ID_instr, IF_ID_pc4;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } word_t;

  // Model: PC, at most one parked word, at most one pending redirect target.
  logic [31:0] m_pc;
  word_t       parked[$];
  logic [31:0] pending[$];
  logic [31:0] m_instr, m_pc4;
  logic        m_valid;
  logic        m_known = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .flush(flush), .PCSrc(PCSrc), .jump(jump), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc4(IF_ID_pc4), .IF_ID_valid(IF_ID_valid),
    .fetch_stall(fetch_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic bubble();
    m_instr = NOP_INSTR;
    m_pc4   = 32'd0;
    m_valid = 1'b0;
  endtask

  // Next model state given this cycle's inputs.
  task automatic model_step();
    logic [31:0] tgt;
    word_t       w;
    if (PCSrc)             tgt = branch_target;
    else if (jump == 2'd2) tgt = jr_target;
    else                   tgt = jump_target;
    tgt[1:0] = 2'b00;
    if (reset) begin
      m_pc = RESET_PC;
      parked.delete();
      pending.delete();
      bubble();
      m_known = 1'b1;
    end else if (pending.size() != 0) begin
      bubble();
      if (flush) pending[0] = tgt;
      if (imem_ready) begin
        m_pc = pending[0];
        pending.delete();
      end
    end else if (parked.size() != 0) begin
      if (flush) begin
        bubble();
        m_pc = tgt;
        parked.delete();
      end else if (PC_write && IF_ID_write) begin
        m_instr = parked[0].instr;
        m_pc4   = parked[0].pc4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
        parked.delete();
      end
    end else begin
      if (flush) begin
        bubble();
        if (imem_ready) m_pc = tgt;
        else            pending.push_back(tgt);
      end else if (imem_ready) begin
        w.instr = mem_word(m_pc);
        w.pc4   = m_pc + 32'd4;
        if (PC_write && IF_ID_write) begin
          m_instr = w.instr;
          m_pc4   = w.pc4;
          m_valid = 1'b1;
          m_pc    = w.pc4;
        end else begin
          parked.push_back(w);
        end
      end else if (IF_ID_write) begin
        bubble();
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic fl, input logic pcw, input logic ifw,
                               input logic src, input logic [1:0] jmp, input logic [31:0] bt,
                               input logic [31:0] jt, input logic [31:0] jr, input logic rdy);
    @(negedge clk);
    reset = rst; flush = fl; PC_write = pcw; IF_ID_write = ifw; PCSrc = src; jump = jmp;
    branch_target = bt; jump_target = jt; jr_target = jr; imem_ready = rdy;
    #1;
    if (m_known) begin
      checkOutput("imem_req", {31'd0, imem_req}, {31'd0, parked.size() == 0});
      checkOutput("imem_addr", imem_addr, m_pc);
      checkOutput("fetch_stall", {31'd0, fetch_stall},
                  {31'd0, (pending.size() != 0) || (parked.size() == 0 && !imem_ready)});
      checkOutput("IF_ID_valid", {31'd0, IF_ID_valid}, {31'd0, m_valid});
      checkOutput("IF_ID_instr", IF_ID_instr, m_instr);
      checkOutput("IF_ID_pc4", IF_ID_pc4, m_pc4);
    end
    model_step();
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(7) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(15));
    return $urandom();
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; PC_write = 1'b1; IF_ID_write = 1'b1; PCSrc = 1'b0;
    jump = 2'd0; branch_target = '0; jump_target = '0; jr_target = '0; imem_ready = 1'b1;

    applyStimulus(1, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
    checkOutput("post_reset_valid", {31'd0, IF_ID_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
      checkOutput("seq_pc4", IF_ID_pc4, RESET_PC + 32'(4 * (i + 1)));
      checkOutput("seq_valid", {31'd0, IF_ID_valid}, 32'd1);
    end

    // Branch and jump together: the branch target must be fetched next.
    applyStimulus(0, 1, 1, 1, 1, 2'd1, 32'h0000_3100, 32'h0000_5000, 32'h0000_4000, 1);
    applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
    checkOutput("branch_addr", imem_addr, 32'h0000_3100);
    checkOutput("flush_valid", {31'd0, IF_ID_valid}, 32'd0);

    // jr flush while imem is waiting: the old address is held until ready.
    applyStimulus(0, 1, 1, 1, 0, 2'd2, 0, 0, 32'h0000_4000, 0);
    applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 0);
    checkOutput("drop_addr", imem_addr, 32'h0000_3104);
    applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 2'd0, 0, 0, 0, 1);
    checkOutput("jr_addr", imem_addr, 32'h0000_4000);

    for (int n = 0; n < 3000; n++) begin
      logic stall;
      stall = ($urandom_range(4) == 0);
      applyStimulus($urandom_range(59) == 0, $urandom_range(9) == 0,
                    stall ? 1'($urandom_range(1)) : 1'b1, stall ? 1'b0 : 1'b1,
                    1'($urandom_range(1)), 2'($urandom_range(3)),
                    rand_target(), rand_target(), rand_target(), $urandom_range(9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
